stall_pipe_consumer: RTL and testbench
======================================

Name: stall_pipe_consumer

Overview:
- Downstream consumer for one producer lane: 32-bit data, valid, flush, with a stall fed back to the producer.
- A DEPTH-stage valid/stall pipeline that applies back-pressure combinationally, clears all stages on flush, and forwards data to a downstream port.
- A sequence checker on the output verifies that accepted values step by STEP, and counts transfers and mismatches.
- One instance is placed per producer lane.

Parameters:
- DEPTH, 3, number of register stages (>=1)
- WIDTH, 32, data width
- STEP, 2, expected increment between consecutive output values

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  producer data valid
- in_data  input  WIDTH  producer data
- in_flush  input  1  producer flush; clears pipeline
- out_stall  output  1  to producer; 1 = input not accepted this cycle
- ds_stall  input  1  downstream back-pressure
- out_valid  output  1  tail stage valid, masked by flush
- out_data  output  WIDTH  tail stage data
- seq_count  output  32  number of output transfers (wraps)
- err_count  output  16  sequence mismatches (saturates at 16'hFFFF)
- err_flag  output  1  sticky, set on first mismatch

Behaviour:
- Reset (async, active-high):
  - all stage valids 0, stage data 0
  - seq_count 0, err_count 0, err_flag 0
  - checker unsynced
  - out_valid 0, out_data 0; out_stall follows its equation, so it is 0 when empty.
- Ready chain (combinational):
  - rdy[D-1] = !v[D-1] | !ds_stall
  - rdy[i] = !v[i] | rdy[i+1]
  - out_stall = !rdy[0] & !in_flush
- Input acceptance: at a clk edge, when in_valid & rdy[0] & !in_flush.
  - Producer holds valid/data while out_stall=1.
  - in_valid=0 with rdy[0]=1 loads a bubble (v[0]<=0).
- Stage i (i>0) loads stage i-1 when rdy[i]; when not rdy[i], stage i holds. Bubbles collapse, so throughput is 1/cycle with no stall.
- Latency: with ds_stall=0, an item accepted in cycle t drives out_data/out_valid in cycle t+DEPTH.
- Output:
  - out_valid = v[D-1] & !in_flush
  - out_data = data[D-1], unmasked
  - transfer = out_valid & !ds_stall
- Flush (in_flush=1):
  - at that edge, all v[] <= 0
  - no input accepted and no output transfer counted
  - checker becomes unsynced
  - stage data registers are not required to clear
  - flush overrides ds_stall and in_valid in the same cycle
- Checker, on each transfer:
  - seq_count <= seq_count+1 (mod 2^32).
  - If unsynced: expect <= out_data+STEP (mod 2^WIDTH); synced <= 1; no compare.
  - If synced and out_data != expect: err_count <= sat(err_count+1); err_flag <= 1; expect <= out_data+STEP (resync).
  - If synced and match: expect <= expect+STEP.
- Wrap-around: expect arithmetic is modulo 2^WIDTH. 32'hFFFF_FFFE followed by 32'h0000_0000 with STEP=2 is a match.
- Reset mid-operation: everything returns to reset values immediately; in-flight items are discarded and not counted.
- ds_stall with an empty tail has no effect. A full pipeline under ds_stall raises out_stall in the same cycle (combinational).

Test Plan:
1. Reset, then in_valid=1 with data 2,4,6,… one per cycle, ds_stall=0, DEPTH=3 -> value 2 appears on out_data 3 cycles after acceptance; one output per cycle; after 10 items, seq_count=10, err_count=0, err_flag=0.
2. Fill pipeline with 2,4,6, then hold ds_stall=1 for 5 cycles while producer offers 8 -> out_stall=1 from the cycle the pipe is full; 8 held by producer; out_data stays 2. Release ds_stall -> 2,4,6,8 emerge in order with no loss or duplication.
3. Insert a single in_valid=0 cycle mid-stream -> bubble reaches the output once; seq_count excludes it; no error.
4. Stream …250,252,254, then in_flush=1 for one cycle with 2 items in flight, then resume at 258 -> in-flight items dropped; out_valid=0 during flush; 258 resyncs the checker; err_count=0.
5. Output sequence 10,12,20,22 -> err_count=1, err_flag=1, 22 matches after resync. Force 16'hFFFF errors plus one more -> err_count stays at 16'hFFFF.
6. Assert reset with 3 items in flight and ds_stall=1 -> out_valid=0, out_stall=0, counters 0 immediately; the next stream starts unsynced with no error.

Source files
------------

// File: rtl/stall_pipe_consumer.sv
// Downstream consumer for one producer lane: a valid/stall pipeline with flush,
// followed by a sequence checker that counts transfers and step mismatches.
module stall_pipe_consumer #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_flush,
  output logic             out_stall,
  input  logic             ds_stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      seq_count,
  output logic [15:0]      err_count,
  output logic             err_flag
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [DEPTH-1:0] v_reg;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0] rdy;

  logic             transfer;
  logic             synced_reg;
  logic [WIDTH-1:0] expected_reg;
  logic [31:0]      seq_count_reg;
  logic [15:0]      err_count_reg;
  logic             err_flag_reg;

  // Stage gi can advance when any stage at or after it has a hole, or the tail drains.
  // Written as a flat reduction rather than a chained recurrence.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
      assign rdy[gi] = !ds_stall || !(&v_reg[DEPTH-1:gi]);
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            v_reg[gi]    <= 1'b0;
            data_reg[gi] <= '0;
          end else if (in_flush) begin
            v_reg[gi]    <= 1'b0;
          end else if (rdy[gi]) begin
            v_reg[gi]    <= in_valid;
            data_reg[gi] <= in_data;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            v_reg[gi]    <= 1'b0;
            data_reg[gi] <= '0;
          end else if (in_flush) begin
            v_reg[gi]    <= 1'b0;
          end else if (rdy[gi]) begin
            v_reg[gi]    <= v_reg[gi-1];
            data_reg[gi] <= data_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_stall = !rdy[0] && !in_flush;
  assign out_valid = v_reg[DEPTH-1] && !in_flush;
  assign out_data  = data_reg[DEPTH-1];
  assign transfer  = out_valid && !ds_stall;

  // The first value after reset or flush only establishes the expected sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      synced_reg    <= 1'b0;
      expected_reg  <= '0;
      seq_count_reg <= '0;
      err_count_reg <= '0;
      err_flag_reg  <= 1'b0;
    end else if (in_flush) begin
      synced_reg    <= 1'b0;
    end else if (transfer) begin
      seq_count_reg <= seq_count_reg + 32'd1;
      synced_reg    <= 1'b1;
      if (!synced_reg || out_data != expected_reg) begin
        expected_reg <= out_data + STEP_W;
      end else begin
        expected_reg <= expected_reg + STEP_W;
      end
      if (synced_reg && out_data != expected_reg) begin
        err_flag_reg <= 1'b1;
        if (err_count_reg != 16'hFFFF) begin
          err_count_reg <= err_count_reg + 16'd1;
        end
      end
    end
  end

  assign seq_count = seq_count_reg;
  assign err_count = err_count_reg;
  assign err_flag  = err_flag_reg;

endmodule

// File: tb/tb_stall_pipe_consumer.sv
// Bench for stall_pipe_consumer: a hand-derived vector table, directed corner sequences
// and a randomized run against a slot-level reference model.
module tb_stall_pipe_consumer;
  localparam int D    = 3;
  localparam int W    = 32;
  localparam int STEP = 2;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_flush;
  logic          out_stall;
  logic          ds_stall;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [31:0]   seq_count;
  logic [15:0]   err_count;
  logic          err_flag;

  stall_pipe_consumer #(.DEPTH(D), .WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_flush(in_flush), .out_stall(out_stall), .ds_stall(ds_stall),
    .out_valid(out_valid), .out_data(out_data), .seq_count(seq_count),
    .err_count(err_count), .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an array of slots; the tail leaves when not stalled, and every
  // item in front of the last free slot moves up by one.
  logic         m_v [D];
  logic [31:0]  m_d [D];
  logic         m_synced;
  logic [31:0]  m_expect;
  logic [31:0]  m_seq;
  logic [15:0]  m_err;
  logic         m_flag;
  logic         cur_iv, cur_fl, cur_ds, m_accept;
  logic [31:0]  cur_id;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ds;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_data;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int last_free(input logic ds);
    int r = -1;
    for (int i = 0; i < D; i++) begin
      if (i == D-1) begin
        if (!m_v[i] || !ds) r = i;
      end else if (!m_v[i]) begin
        r = i;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_synced = 1'b0;
    m_expect = '0;
    m_seq = '0;
    m_err = '0;
    m_flag = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [31:0] id, input logic fl, input logic ds);
    int lf;
    logic ev;
    @(negedge clk);
    in_valid = iv; in_data = id; in_flush = fl; ds_stall = ds;
    cur_iv = iv; cur_id = id; cur_fl = fl; cur_ds = ds;
    #1;
    lf = last_free(ds);
    ev = m_v[D-1] && !fl;
    m_accept = iv && !fl && (lf >= 0);
    chk("out_stall", 32'(out_stall), 32'((lf < 0) && !fl));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) chk("out_data", out_data, m_d[D-1]);
    chk("seq_count", seq_count, m_seq);
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("err_flag", 32'(err_flag), 32'(m_flag));
  endtask

  task automatic commit();
    int lf;
    @(posedge clk);
    if (cur_fl) begin
      for (int i = 0; i < D; i++) m_v[i] = 1'b0;
      m_synced = 1'b0;
    end else begin
      lf = last_free(cur_ds);
      if (m_v[D-1] && !cur_ds) begin
        m_seq = m_seq + 1;
        if (!m_synced) begin
          m_synced = 1'b1;
          m_expect = m_d[D-1] + STEP;
        end else if (m_d[D-1] != m_expect) begin
          m_flag = 1'b1;
          if (m_err != 16'hFFFF) m_err = m_err + 1;
          m_expect = m_d[D-1] + STEP;
        end else begin
          m_expect = m_expect + STEP;
        end
      end
      if (lf >= 0) begin
        for (int i = lf; i > 0; i--) begin
          m_v[i] = m_v[i-1];
          m_d[i] = m_d[i-1];
        end
        m_v[0] = cur_iv;
        m_d[0] = cur_id;
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] id, input logic fl, input logic ds);
    drive(iv, id, fl, ds);
    commit();
  endtask

  task automatic do_reset(input logic ds);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; ds_stall = ds;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_stall", 32'(out_stall), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_seq_count", seq_count, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    @(negedge clk);
    reset = 1'b0; ds_stall = 1'b0;
  endtask

  task automatic drain_and_check(input string tag, input logic [31:0] seq,
                                 input logic [15:0] err, input logic flag);
    for (int i = 0; i < D + 1; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    chk({tag, "_seq"}, seq_count, seq);
    chk({tag, "_err"}, 32'(err_count), 32'(err));
    chk({tag, "_flag"}, 32'(err_flag), 32'(flag));
    commit();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend_v;
    logic [31:0] pend_d, nxt;

    tbl[0]  = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 32'd0};
    for (int i = 3; i < 8; i++) tbl[i] = '{1'b1, 32'd8, 1'b1, 1'b1, 1'b1, 32'd2};
    tbl[8]  = '{1'b1, 32'd8, 1'b0, 1'b0, 1'b1, 32'd2};
    tbl[9]  = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd4};
    tbl[10] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd6};
    tbl[11] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd8};
    tbl[12] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; ds_stall = 1'b0;
    model_reset();

    // Streaming: latency of DEPTH cycles, one output per cycle.
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'(2 + 2*k), 1'b0, 1'b0);
      if (k == D) begin
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_data", out_data, 32'd2);
      end
      commit();
    end
    drain_and_check("stream", 32'd10, 16'd0, 1'b0);

    // Single bubble mid-stream.
    cycle(1'b1, 32'd22, 1'b0, 1'b0);
    cycle(1'b1, 32'd24, 1'b0, 1'b0);
    cycle(1'b1, 32'd26, 1'b0, 1'b0);
    cycle(1'b0, 32'd0,  1'b0, 1'b0);
    cycle(1'b1, 32'd28, 1'b0, 1'b0);
    cycle(1'b1, 32'd30, 1'b0, 1'b0);
    drain_and_check("bubble", 32'd15, 16'd0, 1'b0);

    // Fill then downstream stall: table of hand-derived expectations.
    do_reset(1'b0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].iv, tbl[i].id, 1'b0, tbl[i].ds);
      chk("tbl_stall", 32'(out_stall), 32'(tbl[i].e_stall));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk("tbl_data", out_data, tbl[i].e_data);
      commit();
    end
    drain_and_check("table", 32'd4, 16'd0, 1'b0);

    // Flush with two items in flight, then resume at 258.
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b1, 32'(244 + 2*k), 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'd256, 1'b1, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_stall", 32'(out_stall), 32'd0);
    commit();
    cycle(1'b1, 32'd258, 1'b0, 1'b0);
    cycle(1'b1, 32'd260, 1'b0, 1'b0);
    cycle(1'b1, 32'd262, 1'b0, 1'b0);
    drain_and_check("flush", 32'd7, 16'd0, 1'b0);

    // Modular wrap of the expected value.
    do_reset(1'b0);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0002, 1'b0, 1'b0);
    drain_and_check("wrap", 32'd4, 16'd0, 1'b0);

    // Single mismatch with resync, then saturation.
    do_reset(1'b0);
    cycle(1'b1, 32'd10, 1'b0, 1'b0);
    cycle(1'b1, 32'd12, 1'b0, 1'b0);
    cycle(1'b1, 32'd20, 1'b0, 1'b0);
    cycle(1'b1, 32'd22, 1'b0, 1'b0);
    drain_and_check("mismatch", 32'd4, 16'd1, 1'b1);
    // Stride 4 never matches the expected stride of 2: every item is an error.
    for (int k = 0; k < 65536; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(100 + 4*k); in_flush = 1'b0; ds_stall = 1'b0;
    end
    for (int k = 0; k < D + 2; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    chk("sat_err_count", 32'(err_count), 32'h0000_FFFF);
    chk("sat_err_flag", 32'(err_flag), 32'd1);
    chk("sat_seq_count", seq_count, 32'd65540);

    // Reset mid-operation with a full, stalled pipe.
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(7 + 2*k);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd13; ds_stall = 1'b1;
    #1;
    chk("full_out_stall", 32'(out_stall), 32'd1);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'(51 + 2*k), 1'b0, 1'b0);
    drain_and_check("post_reset", 32'd4, 16'd0, 1'b0);

    // Randomized traffic against the model; producer holds an offer until accepted.
    do_reset(1'b0);
    pend_v = 1'b0;
    pend_d = '0;
    nxt = 32'hFFFF_FF00;
    for (int n = 0; n < 2000; n++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 3) != 0);
        if (pend_v) begin
          pend_d = ($urandom_range(0, 19) == 0) ? $urandom : nxt;
          nxt = pend_d + STEP;
        end
      end
      drive(pend_v, pend_d, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
      commit();
      if (m_accept) pend_v = 1'b0;
    end
    for (int i = 0; i < D + 2; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
